// File: rtl/led_pattern_engine_if.sv
// led_pattern_engine_if: control inputs and LED drive outputs of led_pattern_engine.
// The master side supplies period/mode/mode_load/enable; the slave returns led/active_idx/step_tick.
interface led_pattern_engine_if #(
    parameter int unsigned N_LED    = 8,
    parameter int unsigned PERIOD_W = 4
);
    logic [PERIOD_W-1:0]      period;
    logic [2:0]               mode;
    logic                     mode_load;
    logic                     enable;
    logic [N_LED-1:0]         led;
    logic [$clog2(N_LED)-1:0] active_idx;
    logic                     step_tick;

    modport master (
        output period, mode, mode_load, enable,
        input  led, active_idx, step_tick
    );

    modport slave (
        input  period, mode, mode_load, enable,
        output led, active_idx, step_tick
    );
endinterface

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: prescaler, step timer, per-mode pattern state and shared PWM compare.
// Define GAMMA_EN to compare BREATHE duty through a quadratic gamma ((duty*duty) >> PWM_BITS).
module led_pattern_engine #(
    parameter int unsigned N_LED    = 8,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned TICK_DIV = 12000,
    parameter int unsigned PERIOD_W = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    led_pattern_engine_if.slave bus
);
    localparam int unsigned IDX_W   = $clog2(N_LED);
    localparam int unsigned PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0]  PrescMax = PRESC_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]    IdxMax   = IDX_W'(N_LED - 1);
    localparam logic [PWM_BITS-1:0] DutyStep = PWM_BITS'(1 << (PWM_BITS - 4));
    localparam logic [PWM_BITS-1:0] DutyMax  = PWM_BITS'((1 << PWM_BITS) - (1 << (PWM_BITS - 4)));

    typedef enum logic [2:0] {
        ModeOff     = 3'd0,
        ModeOn      = 3'd1,
        ModeBlink   = 3'd2,
        ModeChase   = 3'd3,
        ModeBounce  = 3'd4,
        ModeBreathe = 3'd5,
        ModeHeart   = 3'd6,
        ModeRsvd    = 3'd7
    } mode_e;

    typedef enum logic [1:0] {StBeat1, StGap, StBeat2, StRest} hb_state_e;

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [PERIOD_W-1:0] step_q, step_d;
    logic [PERIOD_W-1:0] period_l_q, period_l_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    mode_e               mode_q, mode_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                dir_down_q, dir_down_d;  // shared by BOUNCE and BREATHE
    logic                phase_q, phase_d;
    hb_state_e           hb_state_q, hb_state_d;
    logic [3:0]          hb_cnt_q, hb_cnt_d;
    logic [3:0]          hb_last;
    logic [N_LED-1:0]    led_q, led_d, led_pat;
    logic [IDX_W-1:0]    active_idx_q, active_idx_d;
    logic                step_tick_q, step_tick_d;
    logic                base_tick, step_wrap, advance;
    logic [PWM_BITS-1:0] duty_cmp;

    assign base_tick = (presc_q == PrescMax);
    assign step_wrap = bus.enable && base_tick && (step_q == period_l_q);
    // A mode_load in the wrap cycle swallows that step.
    assign advance   = step_wrap && !bus.mode_load;
    assign hb_last   = (hb_state_q == StRest) ? 4'd9 : 4'd1;

`ifdef GAMMA_EN
    logic [2*PWM_BITS-1:0] duty_sq;
    assign duty_sq  = {{PWM_BITS{1'b0}}, duty_q} * {{PWM_BITS{1'b0}}, duty_q};
    assign duty_cmp = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty_cmp = duty_q;
`endif

    // Next state for timers, pattern state and heartbeat FSM.
    always_comb begin
        presc_d     = presc_q;
        step_d      = step_q;
        period_l_d  = period_l_q;
        pwm_d       = pwm_q + 1'b1;
        mode_d      = mode_q;
        idx_d       = idx_q;
        duty_d      = duty_q;
        dir_down_d  = dir_down_q;
        phase_d     = phase_q;
        hb_state_d  = hb_state_q;
        hb_cnt_d    = hb_cnt_q;
        step_tick_d = advance;

        if (bus.enable) begin
            presc_d = base_tick ? '0 : presc_q + 1'b1;
            if (base_tick) begin
                if (step_q == period_l_q) begin
                    step_d     = '0;
                    period_l_d = bus.period;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
        end

        if (advance) begin
            case (mode_q)
                ModeBlink: phase_d = ~phase_q;
                ModeChase: idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
                ModeBounce: begin
                    if (!dir_down_q) begin
                        if (idx_q == IdxMax) begin
                            dir_down_d = 1'b1;
                            idx_d      = idx_q - 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else if (idx_q == '0) begin
                        dir_down_d = 1'b0;
                        idx_d      = idx_q + 1'b1;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
                ModeBreathe: begin
                    if (!dir_down_q) begin
                        if (duty_q == DutyMax) begin
                            dir_down_d = 1'b1;
                            duty_d     = duty_q - DutyStep;
                        end else begin
                            duty_d = duty_q + DutyStep;
                        end
                    end else if (duty_q == '0) begin
                        dir_down_d = 1'b0;
                        duty_d     = duty_q + DutyStep;
                    end else begin
                        duty_d = duty_q - DutyStep;
                    end
                end
                ModeHeart: begin
                    if (hb_cnt_q == hb_last) begin
                        hb_cnt_d = '0;
                        case (hb_state_q)
                            StBeat1: hb_state_d = StGap;
                            StGap:   hb_state_d = StBeat2;
                            StBeat2: hb_state_d = StRest;
                            default: hb_state_d = StBeat1;
                        endcase
                    end else begin
                        hb_cnt_d = hb_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Prescaler and PWM counter deliberately keep running across a load.
        if (bus.mode_load) begin
            mode_d     = mode_e'(bus.mode);
            step_d     = '0;
            idx_d      = '0;
            duty_d     = '0;
            dir_down_d = 1'b0;
            phase_d    = 1'b0;
            hb_state_d = StBeat1;
            hb_cnt_d   = '0;
        end
    end

    // Decode the current pattern state into LED levels.
    always_comb begin
        led_pat = '0;
        case (mode_q)
            ModeOn:                led_pat = '1;
            ModeBlink:             led_pat = {N_LED{phase_q}};
            ModeChase, ModeBounce: led_pat = N_LED'(1) << idx_q;
            ModeBreathe:           led_pat = {N_LED{duty_cmp > pwm_q}};
            ModeHeart:  led_pat = {N_LED{(hb_state_q == StBeat1) || (hb_state_q == StBeat2)}};
            default:               led_pat = '0;
        endcase
        led_d        = bus.enable ? led_pat : '0;
        active_idx_d = ((mode_q == ModeChase) || (mode_q == ModeBounce)) ? idx_q : '0;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q      <= '0;
            step_q       <= '0;
            period_l_q   <= '0;
            pwm_q        <= '0;
            mode_q       <= ModeOff;
            idx_q        <= '0;
            duty_q       <= '0;
            dir_down_q   <= 1'b0;
            phase_q      <= 1'b0;
            hb_state_q   <= StBeat1;
            hb_cnt_q     <= '0;
            led_q        <= '0;
            active_idx_q <= '0;
            step_tick_q  <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            step_q       <= step_d;
            period_l_q   <= period_l_d;
            pwm_q        <= pwm_d;
            mode_q       <= mode_d;
            idx_q        <= idx_d;
            duty_q       <= duty_d;
            dir_down_q   <= dir_down_d;
            phase_q      <= phase_d;
            hb_state_q   <= hb_state_d;
            hb_cnt_q     <= hb_cnt_d;
            led_q        <= led_d;
            active_idx_q <= active_idx_d;
            step_tick_q  <= step_tick_d;
        end
    end

    assign bus.led        = led_q;
    assign bus.active_idx = active_idx_q;
    assign bus.step_tick  = step_tick_q;
endmodule
